// File: rtl/bitwise_logic_unit.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready handshake, tag passthrough and flush.
// Define BITWISE_LOGIC_UNIT_FLAGS_EN to build the eq/zero/ones flag path; otherwise the flag outputs are tied to 0.
module bitwise_logic_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_eq,
    output logic             out_zero,
    output logic             out_ones
);

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_XNOR  = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_ANDN  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] op_result;
    logic             s1_valid, s2_valid;
    logic [WIDTH-1:0] s1_result, s2_result;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic             s2_free, accept, s1_adv;

    assign op       = op_e'(in_op);
    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !flush && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid && s2_free;

    always_comb begin
        op_result = in_a;
        case (op)
            OP_AND:   op_result = in_a & in_b;
            OP_OR:    op_result = in_a | in_b;
            OP_XOR:   op_result = in_a ^ in_b;
            OP_XNOR:  op_result = ~(in_a ^ in_b);
            OP_NAND:  op_result = ~(in_a & in_b);
            OP_NOR:   op_result = ~(in_a | in_b);
            OP_ANDN:  op_result = in_a & ~in_b;
            OP_PASSA: op_result = in_a;
            default:  op_result = in_a;
        endcase
    end

    // Flush wins over a simultaneous output handshake: the S2 result counts as undelivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_free)
                s2_valid <= s1_valid;
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_result <= '0;
            s1_tag    <= '0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else begin
            if (accept) begin
                s1_result <= op_result;
                s1_tag    <= in_tag;
            end
            if (s1_adv) begin
                s2_result <= s1_result;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    logic s1_eq, s2_eq, s2_zero, s2_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_eq   <= 1'b0;
            s2_eq   <= 1'b0;
            s2_zero <= 1'b0;
            s2_ones <= 1'b0;
        end else begin
            if (accept)
                s1_eq <= &(in_a ~^ in_b);
            if (s1_adv) begin
                s2_eq   <= s1_eq;
                s2_zero <= ~|s1_result;
                s2_ones <= &s1_result;
            end
        end
    end

    assign out_eq   = s2_eq;
    assign out_zero = s2_zero;
    assign out_ones = s2_ones;
`else
    assign out_eq   = 1'b0;
    assign out_zero = 1'b0;
    assign out_ones = 1'b0;
`endif

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, two-stage pipelined bitwise logic execution unit for the out-of-order core's integer cluster. It generalises the fixed 64-bit XNOR array to a WIDTH-bit datapath with eight selectable operations. It adds a valid/ready handshake with backpressure, ROB tag passthrough, pipeline flush, and optional equality/zero/all-ones flags for branch-compare consumers. It sits between the issue queue and the writeback arbiter.

## Interface
- WIDTH, 64, operand/result width in bits (≥2)
- TAG_W, 6, ROB tag width carried alongside each operation
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept this cycle
- in_op  input  3  operation select (see Operation)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_tag  input  TAG_W  ROB tag
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  operation result
- out_tag  output  TAG_W  tag of the presented result
- out_eq  output  1  in_a == in_b for that operation
- out_zero  output  1  out_result all zeros
- out_ones  output  1  out_result all ones

## Operation
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 ANDN (a & ~b), 111 PASS_A.
- Stage 1 (S1) register: result, tag, eq (reduction-AND of a XNOR b); s1_valid.
- Stage 2 (S2) register: S1 contents plus zero = ~|result and ones = &result; s2_valid drives out_valid.
- S2 advance: s2_free = !s2_valid || out_ready. S1 advances into S2 when s2_free.
- in_ready = !flush && (!s1_valid || s2_free). This is combinational and has no dependence on in_valid.
- Input accepted when in_valid && in_ready. Result and flags are a pure function of that cycle's in_a/in_b/in_op.
- The output holds stable (result, tag, flags) while out_valid && !out_ready.
- Flush: on a clock edge with flush=1, s1_valid and s2_valid clear. No input is accepted that cycle. Datapath registers keep stale values, which are don't-care while valid=0.
- Flush has priority over a simultaneous output handshake: the result is considered not delivered.
- Reset mid-operation: all in-flight operations are discarded immediately (asynchronous).

## Timing
- Reset values: out_valid=0, out_result=0, out_tag=0, out_eq=0, out_zero=0, out_ones=0. in_ready=1 once rst_n is high and flush=0.
- Latency: accept at edge N, out_valid high after edge N+1, i.e. visible in cycle N+2 relative to the presenting cycle N. This is 2 cycles.
- Throughput: 1 op/cycle while out_ready=1.
- Full: both stages valid and out_ready=0 gives in_ready=0.
- Full with out_ready=1 in the same cycle gives in_ready=1 (pass-through, no bubble).
- Order is strictly preserved. There is no reordering and no drop except by flush.
- rst_n is asserted asynchronously. Deassertion is synchronous to clk, and the external reset synchroniser provides this.

## Configuration
- BITWISE_LOGIC_UNIT_FLAGS_EN defined: eq/zero/ones are computed and registered as above.
- Undefined: flag logic and flag registers are removed. out_eq, out_zero and out_ones are tied to 0. Ports remain and the handshake/latency is unchanged.

## Test plan
- Reset then single op: XNOR a=64'h5555_5555_5555_5555, b=same, tag=3. Required result: out_valid two cycles later, result=64'hFFFF_FFFF_FFFF_FFFF, tag=3, eq=1, ones=1, zero=0.
- Op sweep: a=64'hAAAA_AAAA_AAAA_AAAA, b=64'hFFFF_0000_FFFF_0000 across all eight ops back-to-back. Required: one result per cycle in order, each matching the reference model. For ANDN the result is 64'h0000_AAAA_0000_AAAA.
- Backpressure: stream 4 ops with out_ready=0. Required: in_ready drops after 2 accepts, out_result is held. Then raise out_ready; all 4 ops drain in order with no loss or duplication.
- Flush: fill both stages, assert flush for one cycle with in_valid=1. Required: out_valid=0 the next cycle, the flushed-cycle input is not accepted, and a subsequent op emerges with latency 2.
- Async reset mid-stream: drop rst_n between clock edges while both stages are valid. Required: out_valid=0 immediately, and all outputs return to their reset values.
- Build without BITWISE_LOGIC_UNIT_FLAGS_EN and rerun the first test. Required: identical result and tag, with eq/zero/ones all 0.
